// File: rtl/rf_echo_sequencer.sv
// RF gate sequencer: one trigger produces a full Ramsey or Hahn/CPMG echo pulse train.
// Optional CPMG phase-alternation output enabled by defining RF_PHASE_ALT_EN.
module rf_echo_sequencer #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned N_W     = 8,
  parameter int unsigned DEF_PI2 = 333,
  parameter int unsigned DEF_TAU = 333
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trig,
  input  logic             abort,
  input  logic             mode,
  input  logic [CNT_W-1:0] pi2_len,
  input  logic [CNT_W-1:0] tau_len,
  input  logic [N_W-1:0]   n_pi,
  output logic             rf,
  output logic             busy,
  output logic             done,
  output logic             trig_miss
`ifdef RF_PHASE_ALT_EN
  ,
  output logic             phase
`endif
);

  // One extra bit so 2*pi2 and 2*tau never wrap.
  localparam int unsigned LW = CNT_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_P2A,
    S_TAU1,
    S_PI,
    S_GAP,
    S_P2B,
    S_FIN
  } state_t;

  state_t           state_q, state_d;
  logic [LW-1:0]    cnt_q, cnt_d;
  logic [N_W-1:0]   pic_q, pic_d;
  logic [CNT_W-1:0] pi2_q, pi2_d;
  logic [CNT_W-1:0] tau_q, tau_d;
  logic [N_W-1:0]   n_q, n_d;
  logic             mode_q, mode_d;
  logic             trig_prev_q;
  logic             rf_q, rf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             miss_q, miss_d;
  logic             phase_q, phase_d;

  logic             trig_edge;
  logic             cnt_last;
  logic [CNT_W-1:0] pi2_in, tau_in;
  logic [LW-1:0]    pi2_l, tau_l, pi_l, gap2_l;
  logic [N_W-1:0]   pic_inc;

  assign trig_edge = trig & ~trig_prev_q;
  assign cnt_last  = (cnt_q == '0);
  // Zero lengths are clamped to one cycle at latch time.
  assign pi2_in    = (pi2_len == '0) ? CNT_W'(1) : pi2_len;
  assign tau_in    = (tau_len == '0) ? CNT_W'(1) : tau_len;
  assign pi2_l     = LW'(pi2_q);
  assign tau_l     = LW'(tau_q);
  assign pi_l      = pi2_l << 1;
  assign gap2_l    = tau_l << 1;
  assign pic_inc   = pic_q + N_W'(1);

  // Next-state, counters and registered-output next values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pic_d   = pic_q;
    pi2_d   = pi2_q;
    tau_d   = tau_q;
    n_d     = n_q;
    mode_d  = mode_q;
    phase_d = phase_q;
    miss_d  = trig_edge && (state_q != S_IDLE);

    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      pic_d   = '0;
      phase_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (trig_edge) begin
            pi2_d   = pi2_in;
            tau_d   = tau_in;
            n_d     = n_pi;
            mode_d  = mode;
            state_d = S_P2A;
            cnt_d   = LW'(pi2_in) - LW'(1);
            pic_d   = '0;
            phase_d = 1'b0;
          end
        end
        S_P2A: begin
          if (cnt_last) begin
            state_d = S_TAU1;
            cnt_d   = tau_l - LW'(1);
          end else begin
            cnt_d = cnt_q - LW'(1);
          end
        end
        S_TAU1: begin
          if (cnt_last) begin
            if (mode_q && (n_q != '0)) begin
              state_d = S_PI;
              cnt_d   = pi_l - LW'(1);
              phase_d = ~phase_q;
            end else begin
              state_d = S_P2B;
              cnt_d   = pi2_l - LW'(1);
              phase_d = 1'b0;
            end
          end else begin
            cnt_d = cnt_q - LW'(1);
          end
        end
        S_PI: begin
          if (cnt_last) begin
            state_d = S_GAP;
            pic_d   = pic_inc;
            // Full 2*tau gap between pi pulses, half gap after the last one.
            cnt_d   = (pic_inc < n_q) ? (gap2_l - LW'(1)) : (tau_l - LW'(1));
          end else begin
            cnt_d = cnt_q - LW'(1);
          end
        end
        S_GAP: begin
          if (cnt_last) begin
            if (pic_q < n_q) begin
              state_d = S_PI;
              cnt_d   = pi_l - LW'(1);
              phase_d = ~phase_q;
            end else begin
              state_d = S_P2B;
              cnt_d   = pi2_l - LW'(1);
              phase_d = 1'b0;
            end
          end else begin
            cnt_d = cnt_q - LW'(1);
          end
        end
        S_P2B: begin
          if (cnt_last) begin
            state_d = S_FIN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - LW'(1);
          end
        end
        S_FIN: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // Outputs follow the next state so rf/busy/done are aligned with the state itself.
    rf_d   = (state_d == S_P2A) || (state_d == S_PI) || (state_d == S_P2B);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_FIN);
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      pic_q       <= '0;
      pi2_q       <= CNT_W'(DEF_PI2);
      tau_q       <= CNT_W'(DEF_TAU);
      n_q         <= '0;
      mode_q      <= 1'b0;
      trig_prev_q <= 1'b0;
      rf_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      miss_q      <= 1'b0;
      phase_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pic_q       <= pic_d;
      pi2_q       <= pi2_d;
      tau_q       <= tau_d;
      n_q         <= n_d;
      mode_q      <= mode_d;
      trig_prev_q <= trig;
      rf_q        <= rf_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      miss_q      <= miss_d;
      phase_q     <= phase_d;
    end
  end

  assign rf        = rf_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign trig_miss = miss_q;

`ifdef RF_PHASE_ALT_EN
  assign phase = phase_q;
`else
  logic unused_phase;
  assign unused_phase = phase_q;
`endif

endmodule

// File: tb/tb_rf_echo_sequencer.sv
// Scoreboard bench for rf_echo_sequencer: a waveform-level model expands each accepted
// shot into per-cycle expected outputs; a negedge monitor pops and compares.
module tb_rf_echo_sequencer;

  typedef struct packed {
    logic rf;
    logic busy;
    logic done;
    logic miss;
    logic ph;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        trig;
  logic        abort;
  logic        mode;
  logic [15:0] pi2_len;
  logic [15:0] tau_len;
  logic [7:0]  n_pi;
  logic        rf, busy, done, trig_miss, phase_act;

  logic        trig8, mode8, abort8;
  logic [7:0]  pi8, tau8, n8;
  logic        rf8, busy8, done8, miss8;

  int n_chk;
  int n_fail;
  int cyc;

  exp_t sb_q[$];
  exp_t wave[$];
  exp_t cur_m, nxt_m;
  logic trig_prev_m, edge_m;

  rf_echo_sequencer dut (
    .clk(clk), .rst(rst), .trig(trig), .abort(abort), .mode(mode),
    .pi2_len(pi2_len), .tau_len(tau_len), .n_pi(n_pi),
    .rf(rf), .busy(busy), .done(done), .trig_miss(trig_miss)
`ifdef RF_PHASE_ALT_EN
    , .phase(phase_act)
`endif
  );

  // Narrow instance: exercises the 2*pi2 width extension without a huge runtime.
  rf_echo_sequencer #(.CNT_W(8), .N_W(8), .DEF_PI2(5), .DEF_TAU(5)) dut8 (
    .clk(clk), .rst(rst), .trig(trig8), .abort(abort8), .mode(mode8),
    .pi2_len(pi8), .tau_len(tau8), .n_pi(n8),
    .rf(rf8), .busy(busy8), .done(done8), .trig_miss(miss8)
`ifdef RF_PHASE_ALT_EN
    , .phase()
`endif
  );

`ifndef RF_PHASE_ALT_EN
  assign phase_act = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_run(input logic level, input logic ph, input int len);
    exp_t e;
    e = '{rf: level, busy: 1'b1, done: 1'b0, miss: 1'b0, ph: ph};
    for (int i = 0; i < len; i++) wave.push_back(e);
  endtask

  // Expected waveform of a whole shot, built from the sequence definition.
  task automatic build(input logic m, input logic [15:0] p, input logic [15:0] t,
                       input logic [7:0] n);
    int pp, tt, nn;
    exp_t fin;
    pp = (p == 16'd0) ? 1 : int'(p);
    tt = (t == 16'd0) ? 1 : int'(t);
    nn = int'(n);
    push_run(1'b1, 1'b0, pp);
    push_run(1'b0, 1'b0, tt);
    if (m && nn > 0) begin
      for (int i = 1; i <= nn; i++) begin
        push_run(1'b1, (i % 2) == 1, 2 * pp);
        push_run(1'b0, (i % 2) == 1, (i < nn) ? 2 * tt : tt);
      end
    end
    push_run(1'b1, 1'b0, pp);
    fin = '{rf: 1'b0, busy: 1'b1, done: 1'b1, miss: 1'b0, ph: 1'b0};
    wave.push_back(fin);
  endtask

  initial begin
    cur_m       = '0;
    trig_prev_m = 1'b0;
  end

  // Reference model: decides the next cycle's outputs from this cycle's inputs.
  always @(posedge clk) begin
    cyc++;
    edge_m = trig && !trig_prev_m;
    if (rst) begin
      wave.delete();
      nxt_m = '0;
    end else begin
      if (abort && cur_m.busy) wave.delete();
      else if (edge_m && !cur_m.busy) build(mode, pi2_len, tau_len, n_pi);
      nxt_m = (wave.size() > 0) ? wave.pop_front() : exp_t'('0);
      nxt_m.miss = edge_m && cur_m.busy;
    end
    trig_prev_m = rst ? 1'b0 : trig;
    cur_m = nxt_m;
    sb_q.push_back(nxt_m);
  end

  // Monitor: one comparison per presented output cycle.
  always @(negedge clk) begin
    exp_t e, a;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      a = '{rf: rf, busy: busy, done: done, miss: trig_miss, ph: phase_act};
`ifndef RF_PHASE_ALT_EN
      a.ph = e.ph;
`endif
      n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL outputs cycle %0d: got rf=%b busy=%b done=%b miss=%b ph=%b, want rf=%b busy=%b done=%b miss=%b ph=%b",
                 cyc, a.rf, a.busy, a.done, a.miss, a.ph, e.rf, e.busy, e.done, e.miss, e.ph);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_trig;
    trig = 1'b1;
    tick();
    trig = 1'b0;
  endtask

  task automatic wait_idle;
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 4000 && !ok; i++) begin
      if (!cur_m.busy && wave.size() == 0) ok = 1'b1;
      else tick();
    end
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_idle: got still busy after bound, want idle");
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic wrap_test;
    int runs[$];
    int run;
    bit seen;
    run  = 0;
    seen = 1'b0;
    pi8 = 8'hFF; tau8 = 8'd3; n8 = 8'd1; mode8 = 1'b1;
    trig8 = 1'b1;
    tick();
    trig8 = 1'b0;
    for (int c = 0; c < 3000 && !seen; c++) begin
      @(negedge clk);
      if (rf8) run++;
      else if (run > 0) begin
        runs.push_back(run);
        run = 0;
      end
      if (done8) seen = 1'b1;
    end
    tick();
    chk("wrap_done_seen", int'(seen), 1);
    chk("wrap_run_count", runs.size(), 3);
    chk("wrap_p2a_len", (runs.size() > 0) ? runs[0] : -1, 255);
    chk("wrap_pi_len", (runs.size() > 1) ? runs[1] : -1, 510);
    chk("wrap_p2b_len", (runs.size() > 2) ? runs[2] : -1, 255);
    chk("wrap_busy_after", int'(busy8), 0);
  endtask

  initial begin
    int dur;
    n_chk = 0; n_fail = 0; cyc = 0;
    rst = 1'b1; trig = 1'b0; abort = 1'b0; mode = 1'b0;
    pi2_len = 16'd0; tau_len = 16'd0; n_pi = 8'd0;
    trig8 = 1'b0; abort8 = 1'b0; mode8 = 1'b0; pi8 = 8'd0; tau8 = 8'd0; n8 = 8'd0;
    tick(3);
    rst = 1'b0;
    tick(5);

    // Ramsey 4/6
    mode = 1'b0; pi2_len = 16'd4; tau_len = 16'd6;
    pulse_trig(); wait_idle(); tick(2);

    // Echo 3/5, two pi pulses
    mode = 1'b1; pi2_len = 16'd3; tau_len = 16'd5; n_pi = 8'd2;
    pulse_trig(); wait_idle(); tick(2);

    // Ignored trigger mid-shot with changed inputs
    mode = 1'b1; pi2_len = 16'd4; tau_len = 16'd3; n_pi = 8'd2;
    pulse_trig(); tick(4);
    pi2_len = 16'd9; tau_len = 16'd1; n_pi = 8'd0; mode = 1'b0;
    pulse_trig(); wait_idle(); tick(2);

    // Abort during the first pi pulse, then a clean shot
    mode = 1'b1; pi2_len = 16'd3; tau_len = 16'd4; n_pi = 8'd3;
    pulse_trig(); tick(8);
    abort = 1'b1; tick(); abort = 1'b0;
    tick(2);
    pulse_trig(); wait_idle(); tick(2);

    // Zero lengths clamp to one
    mode = 1'b0; pi2_len = 16'd0; tau_len = 16'd0; n_pi = 8'd0;
    pulse_trig(); wait_idle(); tick(2);

    // Edge in FIN is a miss; edge in first IDLE cycle restarts
    mode = 1'b0; pi2_len = 16'd2; tau_len = 16'd2;
    pulse_trig(); tick(6);
    trig = 1'b1; tick(); trig = 1'b0;
    wait_idle(); tick(2);
    pulse_trig(); tick(7);
    pulse_trig(); wait_idle(); tick(2);

    // Reset mid-TAU1, then default-length shot
    mode = 1'b0; pi2_len = 16'd10; tau_len = 16'd20;
    pulse_trig();
    pi2_len = 16'd333; tau_len = 16'd333;
    tick(13);
    rst = 1'b1; tick(2); rst = 1'b0;
    tick(3);
    pulse_trig(); wait_idle(); tick(2);

    // Randomized shots with stray triggers, input churn and occasional aborts
    for (int s = 0; s < 24; s++) begin
      mode    = 1'($urandom_range(0, 1));
      pi2_len = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom_range(1, 7));
      tau_len = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom_range(1, 7));
      n_pi    = 8'($urandom_range(0, 4));
      pulse_trig();
      dur = int'($urandom_range(0, 40));
      for (int c = 0; c < dur; c++) begin
        if ($urandom_range(0, 7) == 0) trig = ~trig;
        pi2_len = 16'($urandom_range(0, 9));
        tau_len = 16'($urandom_range(0, 9));
        n_pi    = 8'($urandom_range(0, 5));
        mode    = 1'($urandom_range(0, 1));
        abort   = (s % 5 == 3) && (c == dur - 1);
        tick();
      end
      trig = 1'b0; abort = 1'b0;
      wait_idle(); tick(2);
    end

    wrap_test();
    tick(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
